// File: rtl/ace_snoop_responder_if.sv
// ACE snoop channel (AC/CR/CD) plus line-fill port between the snoop responder
// (master modport) and the interconnect/home agent (slave modport).
interface ace_snoop_responder_if #(
   parameter int ADDR_WIDTH       = 64,
   parameter int SNOOP_DATA_WIDTH = 128,
   parameter int LINE_BITS        = 512
);
   logic                        acvalid;
   logic                        acready;
   logic [ADDR_WIDTH-1:0]       acaddr;
   logic [3:0]                  acsnoop;
   logic [2:0]                  acprot;
   logic                        crvalid;
   logic                        crready;
   logic [4:0]                  crresp;
   logic                        cdvalid;
   logic                        cdready;
   logic [SNOOP_DATA_WIDTH-1:0] cddata;
   logic                        cdlast;
   logic                        fill_valid;
   logic                        fill_ready;
   logic [ADDR_WIDTH-1:0]       fill_addr;
   logic [2:0]                  fill_state;
   logic [LINE_BITS-1:0]        fill_data;

   modport master (
      input  acvalid, acaddr, acsnoop, acprot, crready, cdready,
             fill_valid, fill_addr, fill_state, fill_data,
      output acready, crvalid, crresp, cdvalid, cddata, cdlast, fill_ready
   );

   modport slave (
      output acvalid, acaddr, acsnoop, acprot, crready, cdready,
             fill_valid, fill_addr, fill_state, fill_data,
      input  acready, crvalid, crresp, cdvalid, cddata, cdlast, fill_ready
   );
endinterface

// File: rtl/ace_snoop_responder.sv
// Master-side ACE snoop responder: direct-mapped line table, CR response,
// multi-beat CD data from a snapshot taken at lookup, and a line-fill port.
module ace_snoop_responder #(
   parameter int ADDR_WIDTH       = 64,
   parameter int SNOOP_DATA_WIDTH = 128,
   parameter int CACHE_LINE_SIZE  = 6,
   parameter int NUM_LINES        = 16
) (
   input logic                  aclk,
   input logic                  areset,
   ace_snoop_responder_if.master bus
);
   localparam int LINE_BITS = (2 ** CACHE_LINE_SIZE) * 8;
   localparam int IDX_W     = $clog2(NUM_LINES);
   localparam int TAG_W     = ADDR_WIDTH - CACHE_LINE_SIZE - IDX_W;
   localparam int BEATS     = LINE_BITS / SNOOP_DATA_WIDTH;
   localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      RESP   = 2'd2,
      DATA   = 2'd3
   } state_t;

   state_t                      state_r;
   logic [ADDR_WIDTH-1:0]       addr_r;
   logic [3:0]                  snoop_r;
   logic [NUM_LINES-1:0]        valid_r;
   logic [NUM_LINES-1:0]        unique_r;
   logic [NUM_LINES-1:0]        dirty_r;
   logic [TAG_W-1:0]            tag_mem [NUM_LINES];
   logic [LINE_BITS-1:0]        data_mem [NUM_LINES];
   logic [LINE_BITS-1:0]        snap_r;
   logic [BEAT_W-1:0]           beat_r;
   logic                        acready_r;
   logic                        crvalid_r;
   logic [4:0]                  crresp_r;
   logic                        cdvalid_r;
   logic [SNOOP_DATA_WIDTH-1:0] cddata_r;
   logic                        cdlast_r;

   logic [IDX_W-1:0]            idx_s;
   logic [TAG_W-1:0]            tag_s;
   logic                        hit_s;
   logic                        u_s;
   logic                        d_s;
   logic [4:0]                  resp_s;
   logic                        upd_s;
   logic                        nv_s;
   logic                        nu_s;
   logic                        nd_s;
   logic [IDX_W-1:0]            fidx_s;
   logic [TAG_W-1:0]            ftag_s;
   logic                        fill_ready_s;
   logic                        fill_fire_s;
   logic [BEAT_W-1:0]           beat_nxt_s;
   logic                        unused_s;

   assign idx_s        = addr_r[CACHE_LINE_SIZE +: IDX_W];
   assign tag_s        = addr_r[ADDR_WIDTH-1 -: TAG_W];
   assign hit_s        = valid_r[idx_s] && (tag_mem[idx_s] == tag_s);
   assign u_s          = unique_r[idx_s];
   assign d_s          = dirty_r[idx_s];
   assign fidx_s       = bus.fill_addr[CACHE_LINE_SIZE +: IDX_W];
   assign ftag_s       = bus.fill_addr[ADDR_WIDTH-1 -: TAG_W];
   // Fills only land in IDLE, so a snapshot never mixes old state with new data.
   assign fill_ready_s = acready_r && (state_r == IDLE) && !bus.acvalid && !areset;
   assign fill_fire_s  = bus.fill_valid && fill_ready_s;
   assign beat_nxt_s   = beat_r + 1'b1;
   assign unused_s     = ^{bus.acprot, addr_r[CACHE_LINE_SIZE-1:0],
                           bus.fill_addr[CACHE_LINE_SIZE-1:0]};

   // Snoop decode: response bits {WasUnique,IsShared,PassDirty,Error,DataTransfer} and next line state.
   always_comb begin
      resp_s = 5'b00000;
      upd_s  = 1'b0;
      nv_s   = valid_r[idx_s];
      nu_s   = u_s;
      nd_s   = d_s;
      case (snoop_r)
         4'b0000: begin
            if (hit_s) resp_s = {u_s, 1'b1, 1'b0, 1'b0, 1'b1};
            else       resp_s = 5'b00000;
         end
         4'b0001, 4'b0010, 4'b0011: begin
            if (hit_s) begin
               resp_s = {u_s, 1'b1, d_s, 1'b0, 1'b1};
               upd_s  = 1'b1;
               nv_s   = 1'b1;
               nu_s   = 1'b0;
               nd_s   = 1'b0;
            end else begin
               resp_s = 5'b00000;
            end
         end
         4'b0111, 4'b1001, 4'b1101: begin
            if (hit_s) begin
               if (snoop_r == 4'b0111)      resp_s = {u_s, 1'b0, d_s, 1'b0, 1'b1};
               else if (snoop_r == 4'b1001) resp_s = {u_s, 1'b0, d_s, 1'b0, d_s};
               else                         resp_s = {u_s, 4'b0000};
               upd_s = 1'b1;
               nv_s  = 1'b0;
               nu_s  = 1'b0;
               nd_s  = 1'b0;
            end else begin
               resp_s = 5'b00000;
            end
         end
         4'b1000: begin
            if (hit_s) begin
               resp_s = {u_s, 1'b1, d_s, 1'b0, d_s};
               upd_s  = 1'b1;
               nd_s   = 1'b0;
            end else begin
               resp_s = 5'b00000;
            end
         end
         default: resp_s = 5'b00010;
      endcase
   end

   // Line state bits: cleared on reset, written by fills and by snoop lookups.
   always_ff @(posedge aclk) begin
      if (areset) begin
         valid_r  <= '0;
         unique_r <= '0;
         dirty_r  <= '0;
      end else if (fill_fire_s) begin
         {valid_r[fidx_s], unique_r[fidx_s], dirty_r[fidx_s]} <= bus.fill_state;
      end else if (state_r == LOOKUP && upd_s) begin
         {valid_r[idx_s], unique_r[idx_s], dirty_r[idx_s]} <= {nv_s, nu_s, nd_s};
      end
   end

   // Tag and data storage, written only by accepted fills.
   always_ff @(posedge aclk) begin
      if (fill_fire_s) begin
         tag_mem[fidx_s]  <= ftag_s;
         data_mem[fidx_s] <= bus.fill_data;
      end
   end

   // Snoop FSM with registered AC/CR/CD outputs.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r   <= IDLE;
         addr_r    <= '0;
         snoop_r   <= 4'b0000;
         snap_r    <= '0;
         beat_r    <= '0;
         acready_r <= 1'b0;
         crvalid_r <= 1'b0;
         crresp_r  <= 5'b00000;
         cdvalid_r <= 1'b0;
         cddata_r  <= '0;
         cdlast_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (acready_r && bus.acvalid) begin
                  addr_r    <= bus.acaddr;
                  snoop_r   <= bus.acsnoop;
                  acready_r <= 1'b0;
                  state_r   <= LOOKUP;
               end else begin
                  acready_r <= 1'b1;
               end
            end
            LOOKUP: begin
               crresp_r  <= resp_s;
               crvalid_r <= 1'b1;
               snap_r    <= data_mem[idx_s];
               state_r   <= RESP;
            end
            RESP: begin
               if (bus.crready) begin
                  crvalid_r <= 1'b0;
                  if (crresp_r[0]) begin
                     cdvalid_r <= 1'b1;
                     cddata_r  <= snap_r[0 +: SNOOP_DATA_WIDTH];
                     cdlast_r  <= (BEATS == 1);
                     beat_r    <= '0;
                     state_r   <= DATA;
                  end else begin
                     acready_r <= 1'b1;
                     state_r   <= IDLE;
                  end
               end
            end
            DATA: begin
               if (bus.cdready) begin
                  if (beat_r == LAST_BEAT) begin
                     cdvalid_r <= 1'b0;
                     cddata_r  <= '0;
                     cdlast_r  <= 1'b0;
                     acready_r <= 1'b1;
                     state_r   <= IDLE;
                  end else begin
                     beat_r   <= beat_nxt_s;
                     cddata_r <= snap_r[beat_nxt_s*SNOOP_DATA_WIDTH +: SNOOP_DATA_WIDTH];
                     cdlast_r <= (beat_nxt_s == LAST_BEAT);
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign bus.acready    = acready_r;
   assign bus.crvalid    = crvalid_r;
   assign bus.crresp     = crresp_r;
   assign bus.cdvalid    = cdvalid_r;
   assign bus.cddata     = cddata_r;
   assign bus.cdlast     = cdlast_r;
   assign bus.fill_ready = fill_ready_s;
endmodule
